// File: rtl/csc_io_pkg.sv
// Shared definitions for the CPU-mapped nibble UART transmitter.
// NIBBLE_UART_PARITY_EN selects the 11-bit frame with an even parity bit.
package csc_io_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [7:0] DEF_LO_ADDR = 8'hFE;
    localparam logic [7:0] DEF_HI_ADDR = 8'hFF;

    localparam int unsigned DATA_BITS         = 8;
    localparam int unsigned FRAME_BITS_BASE   = 10;
    localparam int unsigned FRAME_BITS_PARITY = 11;

`ifdef NIBBLE_UART_PARITY_EN
    localparam int unsigned FRAME_BITS = FRAME_BITS_PARITY;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    localparam int unsigned FRAME_BITS = FRAME_BITS_BASE;
`endif

endpackage

// File: rtl/nibble_uart_tx_baud_tick.sv
// Bit-period counter: counts while run is high, tick marks the last cycle of each bit.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(CLKS_PER_BIT - 1));
    assign tick = run && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!run || wrap)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/nibble_uart_tx.sv
// Serial transmitter fed by two CPU RAM writes: low nibble, then high nibble to send.
// Build option: NIBBLE_UART_PARITY_EN adds an even parity bit before the stop bit.
module nibble_uart_tx
    import csc_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  LO_ADDR      = DEF_LO_ADDR,
    parameter logic [7:0]  HI_ADDR      = DEF_HI_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] addr,
    input  logic [3:0] wdata,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    tx_state_t  state_q, state_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       ovr_q, ovr_d;
    logic [3:0] lo_q, lo_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] idx_q, idx_d, idx_nx;
    logic       run, tick, lo_wr, hi_wr;

    assign run    = (state_q != IDLE);
    assign lo_wr  = wr_en && (addr == LO_ADDR);
    assign hi_wr  = wr_en && (addr == HI_ADDR);
    assign idx_nx = idx_q + 3'd1;

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            lo_q    <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            lo_q    <= lo_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        lo_d    = lo_q;
        sh_d    = sh_q;
        idx_d   = idx_q;

        if (lo_wr)
            lo_d = wdata;
        // busy is registered, so a write on the edge that ends the stop bit is still dropped
        if (hi_wr)
            ovr_d = busy_q;

        case (state_q)
            IDLE: begin
                if (hi_wr) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    sh_d    = {wdata, lo_q};
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef NIBBLE_UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = even_parity(sh_q);
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_nx;
                        tx_d  = sh_q[idx_nx];
                    end
                end
            end
`ifdef NIBBLE_UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/nibble_uart_tx.md
NIBBLE_UART_TX -- requirements
Module: nibble_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per serial bit (legal range 2..255).
REQ-002 Parameter LO_ADDR, default 8'hFE, SHALL set the write address that latches the low data nibble.
REQ-003 Parameter HI_ADDR, default 8'hFF, SHALL set the write address that latches the high nibble and requests transmission.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL be the CPU RAM write strobe, sampled on the clk rising edge.
REQ-007 addr  input  8  SHALL be the CPU data address.
REQ-008 wdata  input  4  SHALL be the CPU ALU result nibble being written.
REQ-009 tx  output  1  SHALL be the serial line, idle high.
REQ-010 busy  output  1  SHALL be high while a frame is in progress.
REQ-011 overrun  output  1  SHALL be a sticky flag for a byte dropped while busy.

Function
REQ-012 wr_en=1 with addr==LO_ADDR SHALL latch wdata into the low-nibble register at that edge, regardless of busy.
REQ-013 wr_en=1 with addr==HI_ADDR and busy=0 SHALL start a frame with byte {wdata, low nibble}; a low-nibble write in the same cycle is impossible (one address per cycle).
REQ-014 wr_en=1 with addr==HI_ADDR and busy=1 SHALL drop the byte, leave the current frame intact, and set overrun at that edge.
REQ-015 An accepted HI_ADDR write SHALL clear overrun at the same edge.
REQ-016 Writes to any other address SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY, see REQ-026); IDLE->START on accepted write; START->DATA, DATA->STOP after bit 7, STOP->IDLE, each after CLKS_PER_BIT cycles.
REQ-018 If an accepted write occurs at edge N, tx SHALL be 0 and busy 1 from edge N (registered outputs valid after edge N).
REQ-019 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles; data SHALL be sent LSB first; stop bit = 1.
REQ-020 busy SHALL fall at the edge ending the stop bit; frame length 10*CLKS_PER_BIT cycles; a HI_ADDR write in that same cycle sees busy=1 and is dropped.
REQ-021 A HI_ADDR write in the first cycle with busy=0 SHALL start the next frame back-to-back, with no extra idle bit.
REQ-022 The bit-period counter SHALL be sized ceil(log2(CLKS_PER_BIT)) and wrap to 0 at CLKS_PER_BIT-1; the bit index SHALL be 3 bits.

Reset
REQ-023 reset SHALL asynchronously force state IDLE, tx=1, busy=0, overrun=0, low nibble=0, counters=0.
REQ-024 reset asserted mid-frame SHALL abort the frame immediately; tx returns high with no stop bit.
REQ-025 After reset deasserts, the first rising edge SHALL accept writes normally.

Configuration
REQ-026 With NIBBLE_UART_PARITY_EN defined, a PARITY state SHALL sit between DATA and STOP and send the even parity bit (XOR of the 8 data bits), frame = 11*CLKS_PER_BIT cycles; without it there SHALL be no parity logic and the frame is 10*CLKS_PER_BIT cycles.

Structure
REQ-027 Package csc_io_pkg SHALL hold the FSM state encoding, the default LO_ADDR/HI_ADDR constants, and the frame-length constants.
REQ-028 The bit-period counter SHALL be a sub-module baud_tick (inputs clk, reset, run; output tick, high in the last cycle of each bit).

Verification
REQ-029 Reset, write LO=4'h5, HI=4'hA, CLKS_PER_BIT=16 -> tx: 16 cycles 0, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 16 cycles 1; busy high for 160 cycles.
REQ-030 Start 8'h3C, then HI write at cycle 50 of the frame -> frame unchanged, overrun=1; next accepted write (8'h00) clears overrun.
REQ-031 Write 8'hFF, then HI write in the first cycle with busy=0 -> second start bit follows the stop bit with no gap; HI write in the final stop cycle -> dropped, overrun=1.
REQ-032 Assert reset at cycle 70 of a frame -> tx=1, busy=0 asynchronously before the next edge; a new write then transmits correctly.
REQ-033 NIBBLE_UART_PARITY_EN defined, send 8'h07 -> parity bit 1 after bit 7, busy high for 176 cycles; 8'h03 -> parity bit 0.
REQ-034 Writes to addr 8'h10 and 8'hFD -> no tx activity, low-nibble register unchanged.
